posit_conv_issue: RTL and testbench

- Flow-controlled front/back end for the fixed-latency posit-to-double converter.
- Accepts posits on a valid/ready stream and issues them to the converter (conv_in1/conv_start).
- Captures the converter's out/done, patches the special values the converter cannot produce (zero, NaR), and buffers results in an output FIFO with a valid/ready interface.
- Credit-based issue control guarantees the FIFO never overflows, even though the converter has no backpressure.

---
 rtl/posit_conv_issue_if.sv | 40 ++++
 rtl/posit_conv_issue.sv | 181 ++++++++++++++++++
 tb/tb_posit_conv_issue.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/posit_conv_issue_if.sv
`default_nettype none
// ============================================================================
//  Module      : posit_conv_issue_if
//  Description : Stream and converter-side signals of the posit-to-double
//                issue/collect block, bundled with directional views.
//  Revision    : 1.0  initial release
// ============================================================================
interface posit_conv_issue_if #(
    parameter int N = 36
);
    // Posit input stream
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_data;
    // Converter side
    logic [N-1:0] conv_in1;
    logic         conv_start;
    logic [63:0]  conv_out;
    logic         conv_done;
    // Result stream
    logic         out_valid;
    logic         out_ready;
    logic [63:0]  out_data;
    logic [1:0]   out_flags;
    // Status
    logic         err;

    // View of the issue block itself
    modport slave (
        input  in_valid, in_data, conv_out, conv_done, out_ready,
        output in_ready, conv_in1, conv_start, out_valid, out_data, out_flags, err
    );

    // View of everything around the issue block (source, converter, sink)
    modport master (
        output in_valid, in_data, conv_out, conv_done, out_ready,
        input  in_ready, conv_in1, conv_start, out_valid, out_data, out_flags, err
    );
endinterface
`default_nettype wire

// File: rtl/posit_conv_issue.sv
`default_nettype none
// ============================================================================
//  Module      : posit_conv_issue
//  Description : Credit-controlled front/back end for a fixed-latency
//                posit-to-double converter. Issues posits, patches zero/NaR,
//                and buffers results in a first-word-fall-through FIFO.
//  Revision    : 1.0  initial release
// ============================================================================
module posit_conv_issue #(
    parameter int N     = 36,
    parameter int ES    = 5,
    parameter int LAT   = 2,
    parameter int DEPTH = 4
) (
    input wire                clk,
    input wire                rst,
    posit_conv_issue_if.slave bus
);

    localparam int c_CRED_W  = $clog2(DEPTH + 1);
    localparam int c_PTR_W   = $clog2(DEPTH);
    localparam int c_FLUSH_W = $clog2(LAT + 1);

    localparam logic [c_CRED_W-1:0]  c_DEPTH     = c_CRED_W'(DEPTH);
    localparam logic [c_CRED_W-1:0]  c_CRED_ONE  = c_CRED_W'(1);
    localparam logic [c_PTR_W-1:0]   c_PTR_ONE   = c_PTR_W'(1);
    localparam logic [c_FLUSH_W-1:0] c_LAT       = c_FLUSH_W'(LAT);
    localparam logic [c_FLUSH_W-1:0] c_FLUSH_ONE = c_FLUSH_W'(1);
    localparam logic [N-1:0]         c_NAR       = {1'b1, {(N-1){1'b0}}};
    localparam logic [63:0]          c_QNAN      = 64'h7FF8_0000_0000_0000;

    // Parameter sanity: elaboration stops on an unusable configuration
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("posit_conv_issue: DEPTH must be a power of two >= 2");
    end
    if (LAT < 1) begin : g_bad_lat
        $error("posit_conv_issue: LAT must be at least 1");
    end
    if (ES >= N - 2) begin : g_bad_es
        $error("posit_conv_issue: ES too large for N");
    end

    typedef enum logic [0:0] {
        S_FLUSH = 1'b0,
        S_RUN   = 1'b1
    } state_t;

    state_t                 r_state;
    logic [c_FLUSH_W-1:0]   r_flush_cnt;
    logic [c_CRED_W-1:0]    r_credits;
    logic [c_CRED_W-1:0]    w_credits_nxt;
    logic                   r_in_ready;
    logic                   r_err;

    logic                   w_accept;
    logic                   w_pop;
    logic                   w_in_zero;
    logic                   w_in_nar;

    logic [2:0]             r_tag [LAT];
    logic                   w_tag_v;
    logic                   w_tag_nar;
    logic                   w_tag_zero;

    logic [65:0]            r_mem [DEPTH];
    logic [c_PTR_W-1:0]     r_wptr;
    logic [c_PTR_W-1:0]     r_rptr;
    logic [c_CRED_W-1:0]    r_count;
    logic [65:0]            w_entry;
    logic [65:0]            w_head;
    logic                   w_out_valid;

    // Issue side: posit goes straight to the converter, start only on accept
    assign w_accept       = bus.in_valid & r_in_ready;
    assign bus.conv_in1   = bus.in_data;
    assign bus.conv_start = w_accept;
    assign bus.in_ready   = r_in_ready;

    assign w_in_zero = (bus.in_data == '0);
    assign w_in_nar  = (bus.in_data == c_NAR);

    assign {w_tag_v, w_tag_nar, w_tag_zero} = r_tag[LAT-1];

    // Converter result is overridden for the two values it cannot produce
    assign w_entry = {w_tag_nar, w_tag_zero,
                      w_tag_nar ? c_QNAN : (w_tag_zero ? 64'h0 : bus.conv_out)};

    assign w_out_valid   = (r_count != '0);
    assign w_pop         = w_out_valid & bus.out_ready;
    assign w_head        = r_mem[r_rptr];
    assign bus.out_valid = w_out_valid;
    assign bus.out_data  = w_out_valid ? w_head[63:0]  : 64'h0;
    assign bus.out_flags = w_out_valid ? w_head[65:64] : 2'b00;
    assign bus.err       = r_err;

    // Credits count every result that is in flight or buffered
    always_comb begin
        w_credits_nxt = r_credits;
        case ({w_accept, w_pop})
            2'b10:   w_credits_nxt = r_credits + c_CRED_ONE;
            2'b01:   w_credits_nxt = r_credits - c_CRED_ONE;
            default: w_credits_nxt = r_credits;
        endcase
    end

    // Control FSM: flush stale converter starts, then run with credit-gated ready
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_FLUSH;
            r_flush_cnt <= c_LAT;
            r_credits   <= '0;
            r_in_ready  <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_credits <= w_credits_nxt;
            case (r_state)
                S_FLUSH: begin
                    r_flush_cnt <= r_flush_cnt - c_FLUSH_ONE;
                    if (r_flush_cnt == c_FLUSH_ONE) begin
                        r_state    <= S_RUN;
                        r_in_ready <= (w_credits_nxt < c_DEPTH);
                    end
                end
                S_RUN: begin
                    r_in_ready <= (w_credits_nxt < c_DEPTH);
                    if (w_tag_v != bus.conv_done) begin
                        r_err <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= S_FLUSH;
                    r_in_ready <= 1'b0;
                end
            endcase
        end
    end

    // Tag pipe mirrors the converter latency so the tag lines up with done
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++) begin
                r_tag[i] <= 3'b000;
            end
        end else begin
            r_tag[0] <= {w_accept, w_in_nar, w_in_zero};
            for (int i = 1; i < LAT; i++) begin
                r_tag[i] <= r_tag[i-1];
            end
        end
    end

    // FIFO pointers and occupancy; push is driven by the tag, not conv_done
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_tag_v) begin
                r_wptr <= r_wptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_PTR_ONE;
            end
            case ({w_tag_v, w_pop})
                2'b10:   r_count <= r_count + c_CRED_ONE;
                2'b01:   r_count <= r_count - c_CRED_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // FIFO storage; contents are don't-care while empty since outputs are gated
    always_ff @(posedge clk) begin
        if (w_tag_v) begin
            r_mem[r_wptr] <= w_entry;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_posit_conv_issue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_posit_conv_issue
//  Description : Directed bench for posit_conv_issue with a fixed-latency
//                converter model and hand-computed expected results.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_posit_conv_issue;

    localparam int          c_N     = 36;
    localparam int          c_LAT   = 2;
    localparam int          c_DEPTH = 4;
    localparam logic [35:0] c_ONE   = 36'h4_0000_0000;
    localparam logic [35:0] c_NAR   = 36'h8_0000_0000;
    localparam logic [63:0] c_DONE  = 64'h3FF0_0000_0000_0000;
    localparam logic [63:0] c_QNAN  = 64'h7FF8_0000_0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        extra_done = 1'b0;
    logic        p_v [c_LAT];
    logic [63:0] p_d [c_LAT];

    int errors = 0;
    int checks = 0;

    posit_conv_issue_if #(.N(c_N)) bus ();

    posit_conv_issue #(
        .N     (c_N),
        .ES    (5),
        .LAT   (c_LAT),
        .DEPTH (c_DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Converter stand-in: 1.0 maps to its true double, anything else to a
    // recognisable non-IEEE pattern (so zero/NaR patching is visible)
    function automatic logic [63:0] conv_model(input logic [35:0] p);
        return (p == c_ONE) ? c_DONE : {28'hC0FFEE0, p};
    endfunction

    function automatic logic [65:0] exp_of(input logic [35:0] p);
        if (p == 36'h0) return {2'b01, 64'h0};
        if (p == c_NAR) return {2'b10, c_QNAN};
        return {2'b00, conv_model(p)};
    endfunction

    function automatic logic [35:0] rand_posit();
        int unsigned r  = $urandom_range(0, 9);
        logic [31:0] lo = $urandom;
        logic [3:0]  hi = 4'($urandom);
        case (r)
            0:       return 36'h0;
            1:       return c_NAR;
            2:       return c_ONE;
            default: return {hi, lo};
        endcase
    endfunction

    // Fixed-latency converter pipeline (no reset, like the real one)
    always @(posedge clk) begin
        p_v[0] <= bus.conv_start;
        p_d[0] <= conv_model(bus.conv_in1);
        p_v[1] <= p_v[0];
        p_d[1] <= p_d[0];
    end
    assign bus.conv_done = p_v[c_LAT-1] | extra_done;
    assign bus.conv_out  = p_d[c_LAT-1];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [65:0] obs, input logic [65:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for a result, check it, and let it pop (out_ready=1)
    task automatic pop_expect(input string tag, input logic [65:0] exp);
        int n = 0;
        while (!bus.out_valid && n < 20) begin
            step();
            n++;
        end
        chk({tag, "_valid"}, bus.out_valid, 1);
        chk(tag, {bus.out_flags, bus.out_data}, exp);
        step();
    endtask

    initial begin
        int          idx;
        int          sent;
        int          cyc;
        int          n;
        logic        pending;
        logic [65:0] q [$];

        // ---------------- reset and flush ----------------
        bus.in_valid  = 1'b1;
        bus.in_data   = c_ONE;
        bus.out_ready = 1'b1;
        step();
        chk("rst_in_ready",   bus.in_ready,   0);
        chk("rst_conv_start", bus.conv_start, 0);
        chk("rst_out_valid",  bus.out_valid,  0);
        chk("rst_out_data",   bus.out_data,   0);
        chk("rst_out_flags",  bus.out_flags,  0);
        chk("rst_err",        bus.err,        0);

        rst        = 1'b0;
        extra_done = 1'b1;
        step();
        chk("flush_in_ready",  bus.in_ready,  0);
        chk("flush_out_valid", bus.out_valid, 0);
        step();
        extra_done = 1'b0;
        #1;
        chk("run_in_ready",     bus.in_ready,   1);
        chk("issue_start",      bus.conv_start, 1);
        chk("issue_in1",        bus.conv_in1,   c_ONE);
        chk("flush_err",        bus.err,        0);
        chk("flush_out_valid2", bus.out_valid,  0);

        // ---------------- single 1.0, latency LAT+1 ----------------
        step();
        bus.in_valid = 1'b0;
        #1;
        chk("issue_one_shot", bus.conv_start, 0);
        chk("lat_t1",         bus.out_valid,  0);
        step();
        chk("lat_t2",         bus.out_valid,  0);
        step();
        chk("lat_t3_valid",   bus.out_valid,  1);
        chk("lat_t3_result",  {bus.out_flags, bus.out_data}, {2'b00, c_DONE});
        step();
        chk("lat_popped",     bus.out_valid,  0);
        chk("lat_err",        bus.err,        0);

        // ---------------- zero then NaR ----------------
        bus.in_valid = 1'b1;
        bus.in_data  = 36'h0;
        step();
        bus.in_data  = c_NAR;
        step();
        bus.in_valid = 1'b0;
        pop_expect("zero", {2'b01, 64'h0});
        pop_expect("nar",  {2'b10, c_QNAN});

        // ---------------- backpressure: only DEPTH accepted ----------------
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        idx = 0;
        for (int k = 0; k < 10; k++) begin
            bus.in_data = 36'h1_2345_0000 + 36'(idx);
            #1;
            if (bus.conv_start) idx++;
            step();
        end
        chk("bp_accepted",  idx,           c_DEPTH);
        chk("bp_in_ready",  bus.in_ready,  0);
        chk("bp_out_valid", bus.out_valid, 1);
        bus.in_data   = 36'h1_2345_0004;
        bus.out_ready = 1'b1;
        #1;
        chk("bp_no_accept_before_pop", bus.conv_start, 0);
        chk("bp_head", {bus.out_flags, bus.out_data}, exp_of(36'h1_2345_0000));
        step();
        bus.in_valid = 1'b0;
        chk("bp_ready_after_pop", bus.in_ready, 1);
        pop_expect("bp1", exp_of(36'h1_2345_0001));
        pop_expect("bp2", exp_of(36'h1_2345_0002));
        pop_expect("bp3", exp_of(36'h1_2345_0003));
        chk("bp_drained", bus.out_valid, 0);

        // ---------------- random traffic, 1000 posits ----------------
        sent    = 0;
        cyc     = 0;
        pending = 1'b0;
        while ((sent < 1000 || q.size() != 0) && cyc < 20000) begin
            if (!pending) begin
                bus.in_valid = (sent < 1000) && ($urandom_range(0, 3) != 0);
                bus.in_data  = rand_posit();
            end
            bus.out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (bus.in_valid && bus.in_ready) begin
                q.push_back(exp_of(bus.in_data));
                sent++;
                pending = 1'b0;
            end else begin
                pending = bus.in_valid;
            end
            if (bus.out_valid && bus.out_ready) begin
                chk("rand_has_expect", q.size() != 0, 1);
                if (q.size() != 0) chk("rand_result", {bus.out_flags, bus.out_data}, q.pop_front());
            end
            chk("rand_credits", q.size() <= c_DEPTH, 1);
            step();
            cyc++;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        chk("rand_all_sent",    sent,     1000);
        chk("rand_queue_empty", q.size(), 0);
        chk("rand_err",         bus.err,  0);

        // ---------------- spurious conv_done -> sticky err ----------------
        step();
        extra_done = 1'b1;
        step();
        extra_done = 1'b0;
        step();
        chk("err_set",       bus.err,       1);
        chk("err_no_output", bus.out_valid, 0);
        step();
        step();
        chk("err_sticky",    bus.err,       1);

        // ---------------- reset with work in flight and buffered ----------------
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = c_ONE;
        for (int k = 0; k < 4; k++) step();
        chk("pre_rst_buffered", bus.out_valid, 1);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_out_valid", bus.out_valid, 0);
        chk("mid_rst_in_ready",  bus.in_ready,  0);
        chk("mid_rst_err",       bus.err,       0);
        chk("mid_rst_out_data",  bus.out_data,  0);
        bus.out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            chk("no_stale_result", bus.out_valid, 0);
        end
        chk("post_rst_in_ready", bus.in_ready, 1);
        chk("post_rst_err",      bus.err,      0);

        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        n = 0;
        for (int k = 0; k < 8; k++) begin
            #1;
            if (bus.conv_start) n++;
            step();
        end
        chk("post_rst_credits", n, c_DEPTH);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) pop_expect("post_rst_result", {2'b00, c_DONE});
        chk("post_rst_drained", bus.out_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
